// File: rtl/leaf_user_merge_endpoint.sv
// rtl/leaf_user_merge_endpoint.sv - two-input vld/ack responder with round-robin merge onto one output stream
// Each input is buffered in its own FIFO; a single output register keeps full rate with no bubbles.

module leaf_user_merge_fifo #(
   parameter int W  = 32,
   parameter int AB = 2
) (
   input  logic         clk_user,
   input  logic         reset_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   localparam int DEPTH = 1 << AB;
   localparam logic [AB:0] FULL_OCC = {1'b1, {AB{1'b0}}};

   logic [W-1:0]  mem [DEPTH];
   logic [AB-1:0] wr_ptr;
   logic [AB-1:0] rd_ptr;
   logic [AB:0]   occ;

   assign full    = (occ == FULL_OCC);
   assign empty   = (occ == '0);
   assign rd_data = mem[rd_ptr];

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_user) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end
endmodule

module leaf_user_merge_endpoint #(
   parameter int PAYLOAD_BITS    = 32,
   parameter int FIFO_DEPTH_BITS = 2,
   parameter int CNT_BITS        = 16
) (
   input  logic                    clk_user,
   input  logic                    reset_n,
   input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_1,
   input  logic                    vld_interface2user_1,
   output logic                    ack_user2interface_1,
   input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_2,
   input  logic                    vld_interface2user_2,
   output logic                    ack_user2interface_2,
   output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_1,
   output logic                    vld_user2interface_1,
   input  logic                    ack_interface2user_1,
   output logic [CNT_BITS-1:0]     fwd_count
);
   logic                    running;
   logic [1:0]              last;
   logic                    full_1, full_2, empty_1, empty_2;
   logic [PAYLOAD_BITS-1:0] head_1, head_2;
   logic                    wr_1, wr_2, pop_1, pop_2;
   logic                    load, sel_2;

   // Accepts depend only on registered state, so there is no vld->ack path.
   assign ack_user2interface_1 = running && !full_1;
   assign ack_user2interface_2 = running && !full_2;
   assign wr_1 = vld_interface2user_1 && ack_user2interface_1;
   assign wr_2 = vld_interface2user_2 && ack_user2interface_2;

   always_comb begin
      sel_2 = 1'b0;
      if (!empty_1 && !empty_2) sel_2 = (last == 2'd1);
      else                      sel_2 = empty_1;
      load  = (!vld_user2interface_1 || ack_interface2user_1) && (!empty_1 || !empty_2);
      pop_1 = load && !sel_2;
      pop_2 = load && sel_2;
   end

   leaf_user_merge_fifo #(.W(PAYLOAD_BITS), .AB(FIFO_DEPTH_BITS)) u_fifo_1 (
      .clk_user(clk_user), .reset_n(reset_n),
      .wr_en(wr_1), .wr_data(dout_leaf_interface2user_1),
      .rd_en(pop_1), .rd_data(head_1), .full(full_1), .empty(empty_1)
   );

   leaf_user_merge_fifo #(.W(PAYLOAD_BITS), .AB(FIFO_DEPTH_BITS)) u_fifo_2 (
      .clk_user(clk_user), .reset_n(reset_n),
      .wr_en(wr_2), .wr_data(dout_leaf_interface2user_2),
      .rd_en(pop_2), .rd_data(head_2), .full(full_2), .empty(empty_2)
   );

   always_ff @(posedge clk_user or negedge reset_n) begin
      if (!reset_n) begin
         running                   <= 1'b0;
         vld_user2interface_1      <= 1'b0;
         din_leaf_user2interface_1 <= '0;
         last                      <= 2'd2;
         fwd_count                 <= '0;
      end else begin
         running <= 1'b1;
         if (load) begin
            din_leaf_user2interface_1 <= sel_2 ? head_2 : head_1;
            vld_user2interface_1      <= 1'b1;
            last                      <= sel_2 ? 2'd2 : 2'd1;
         end else if (ack_interface2user_1) begin
            vld_user2interface_1 <= 1'b0;
         end
         if (vld_user2interface_1 && ack_interface2user_1)
            fwd_count <= fwd_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_leaf_user_merge_endpoint.sv
// tb/tb_leaf_user_merge_endpoint.sv - scoreboard bench for leaf_user_merge_endpoint
module tb_leaf_user_merge_endpoint;
   logic        clk_user = 1'b0;
   logic        reset_n  = 1'b0;
   logic [31:0] d1 = '0, d2 = '0;
   logic        v1 = 1'b0, v2 = 1'b0;
   logic        a1, a2;
   logic [31:0] dout;
   logic        vout;
   logic        ack_in = 1'b0;
   logic [15:0] fwd_count;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb_q[$];
   int          tb_xfers = 0;
   int          cyc = 0;
   int          first_cyc = -1;
   int          last_cyc = -1;

   leaf_user_merge_endpoint #(.PAYLOAD_BITS(32), .FIFO_DEPTH_BITS(2), .CNT_BITS(16)) dut (
      .clk_user(clk_user),
      .reset_n(reset_n),
      .dout_leaf_interface2user_1(d1),
      .vld_interface2user_1(v1),
      .ack_user2interface_1(a1),
      .dout_leaf_interface2user_2(d2),
      .vld_interface2user_2(v2),
      .ack_user2interface_2(a2),
      .din_leaf_user2interface_1(dout),
      .vld_user2interface_1(vout),
      .ack_interface2user_1(ack_in),
      .fwd_count(fwd_count)
   );

   always #5 clk_user = ~clk_user;
   always @(posedge clk_user) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: a transfer happens on the coming edge when vld && ack at the falling edge.
   always @(negedge clk_user) begin
      if (reset_n && vout && ack_in) begin
         check("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
         if (sb_q.size() > 0) check("out_data", 64'(dout), 64'(sb_q.pop_front()));
         tb_xfers++;
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
      end
   end

   task automatic send_word(input int port, input logic [31:0] data);
      bit done = 0;
      if (port == 1) begin v1 = 1'b1; d1 = data; end
      else           begin v2 = 1'b1; d2 = data; end
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk_user);
         if ((port == 1) ? a1 : a2) done = 1;
      end
      if (!done) check("send_timeout", 64'd0, 64'd1);
      @(posedge clk_user); #1;
      if (port == 1) v1 = 1'b0; else v2 = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      v1 = 1'b0; v2 = 1'b0;
      repeat (2) @(posedge clk_user);
      sb_q.delete();
      tb_xfers = 0; first_cyc = -1; last_cyc = -1;
      @(negedge clk_user) reset_n = 1'b1;
      @(posedge clk_user); #1;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk_user);
      @(posedge clk_user); #1;
      check({"drain_", tag}, 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #1500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      // 1) reset release
      repeat (2) @(posedge clk_user); #1;
      check("rst_ack1", 64'(a1), 64'd0);
      check("rst_ack2", 64'(a2), 64'd0);
      check("rst_vld", 64'(vout), 64'd0);
      check("rst_din", 64'(dout), 64'd0);
      check("rst_cnt", 64'(fwd_count), 64'd0);
      @(negedge clk_user) reset_n = 1'b1;
      #1 check("rel_ack1_pre", 64'(a1), 64'd0);
      @(posedge clk_user); #1;
      check("rel_ack1", 64'(a1), 64'd1);
      check("rel_ack2", 64'(a2), 64'd1);
      check("rel_vld", 64'(vout), 64'd0);

      // 2) single word latency
      ack_in = 1'b1;
      sb_q.push_back(32'hA000_0001);
      send_word(1, 32'hA000_0001);
      @(posedge clk_user); #1;
      check("t2_vld", 64'(vout), 64'd1);
      check("t2_din", 64'(dout), 64'hA000_0001);
      @(posedge clk_user); #1;
      check("t2_cnt", 64'(fwd_count), 64'd1);
      check("t2_vld_off", 64'(vout), 64'd0);

      // 3) both ports streaming, round-robin starting at port 1
      do_reset();
      ack_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back(32'h1000 + i);
         sb_q.push_back(32'h2000 + i);
      end
      fork
         for (int i = 0; i < 4; i++) send_word(1, 32'h1000 + i);
         for (int j = 0; j < 4; j++) send_word(2, 32'h2000 + j);
      join
      wait_drain("t3");
      check("t3_xfers", 64'(tb_xfers), 64'd8);
      check("t3_consecutive", 64'(last_cyc - first_cyc), 64'd7);
      check("t3_cnt", 64'(fwd_count), 64'd8);

      // 4) + 5) output stalled: backpressure and stable output
      do_reset();
      ack_in = 1'b0;
      for (int i = 0; i < 6; i++) sb_q.push_back(32'h3000 + i);
      for (int i = 0; i < 5; i++) send_word(1, 32'h3000 + i);
      check("t4_ack_full", 64'(a1), 64'd0);
      fork
         send_word(1, 32'h3005);
         begin
            for (int k = 0; k < 3; k++) begin
               @(posedge clk_user); #1;
               check("t5_vld", 64'(vout), 64'd1);
               check("t5_din", 64'(dout), 64'h3000);
            end
            ack_in = 1'b1;
         end
      join
      wait_drain("t4");
      check("t4_cnt", 64'(fwd_count), 64'd6);

      // 6) reset mid-operation discards buffered words
      do_reset();
      ack_in = 1'b0;
      fork
         for (int i = 0; i < 4; i++) send_word(1, 32'h4000 + i);
         for (int j = 0; j < 3; j++) send_word(2, 32'h5000 + j);
      join
      check("t6_vld_pre", 64'(vout), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("t6_vld", 64'(vout), 64'd0);
      check("t6_din", 64'(dout), 64'd0);
      check("t6_ack1", 64'(a1), 64'd0);
      check("t6_ack2", 64'(a2), 64'd0);
      ack_in = 1'b1;
      @(negedge clk_user) reset_n = 1'b1;
      repeat (10) @(posedge clk_user); #1;
      check("t6_no_stale", 64'(tb_xfers), 64'd0);
      check("t6_cnt", 64'(fwd_count), 64'd0);

      // 7) counter wrap after 65536 transfers
      do_reset();
      ack_in = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         sb_q.push_back(32'(i));
         send_word(1, 32'(i));
      end
      wait_drain("t7");
      check("t7_xfers", 64'(tb_xfers), 64'd65536);
      check("t7_wrap", 64'(fwd_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
